// File: rtl/lmfe_in_feeder.sv
`default_nettype none
// ============================================================================
// Module  : lmfe_in_feeder
// Brief   : Buffers a host pixel stream and feeds exactly one frame into the
//           LMFE engine per start pulse, honouring engine back-pressure.
// Revision: 1.0 - initial release
// ============================================================================
module lmfe_in_feeder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int CW    = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    host_data,
    input  logic          host_valid,
    output logic          host_ready,
    output logic [7:0]    Din,
    output logic          in_en,
    input  logic          busy,
    output logic          active,
    output logic          frame_done,
    output logic [AW:0]   fifo_level
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_feed = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Counters carry one extra bit so acc_cnt can actually reach FRAME_PIX.
    localparam int          c_frame_pix_i = IMG_W * IMG_H;
    localparam logic [CW:0] c_frame_pix   = (CW+1)'(c_frame_pix_i);
    localparam logic [CW:0] c_last_pix    = (CW+1)'(c_frame_pix_i - 1);
    localparam logic [CW:0] c_cnt_one     = (CW+1)'(1);
    localparam logic [AW:0] c_depth       = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_lvl_one     = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one   = AW'(1);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic          r_frame_done;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [CW:0]   r_acc_cnt;
    logic [CW:0]   r_out_cnt;

    logic          w_frame_start;
    logic          w_host_ready;
    logic          w_in_en;
    logic          w_push;
    logic          w_pop;
    logic          w_last_xfer;

    // Handshake decode: host_ready depends only on registers, in_en also on busy.
    assign w_frame_start = (r_state == c_st_idle) && start;
    assign w_host_ready  = (r_state == c_st_feed) && (r_level < c_depth)
                           && (r_acc_cnt < c_frame_pix);
    assign w_in_en       = (r_state == c_st_feed) && (r_level != '0) && !busy;
    assign w_push        = host_valid && w_host_ready;
    assign w_pop         = w_in_en;
    assign w_last_xfer   = w_pop && (r_out_cnt == c_last_pix);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_frame_done <= (w_next_state == c_st_done);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (start)       w_next_state = c_st_feed;
            c_st_feed: if (w_last_xfer) w_next_state = c_st_done;
            c_st_done:                  w_next_state = c_st_idle;
            default:                    w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        active     = (r_state != c_st_idle);
        frame_done = r_frame_done;
        host_ready = w_host_ready;
        in_en      = w_in_en;
        fifo_level = r_level;
        Din        = (r_level != '0) ? r_mem[r_rd_ptr] : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_cnt <= '0;
            r_out_cnt <= '0;
        end else if (w_frame_start) begin
            r_acc_cnt <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_push) r_acc_cnt <= r_acc_cnt + c_cnt_one;
            if (w_pop)  r_out_cnt <= r_out_cnt + c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= host_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_lmfe_in_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_lmfe_in_feeder
// Brief   : Self-checking bench for lmfe_in_feeder against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lmfe_in_feeder;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int IMG_W = 4;
    localparam int IMG_H = 2;
    localparam int CW    = 3;
    localparam int FP    = IMG_W * IMG_H;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  host_data;
    logic        host_valid;
    logic        host_ready;
    logic [7:0]  Din;
    logic        in_en;
    logic        busy;
    logic        active;
    logic        frame_done;
    logic [AW:0] fifo_level;
    logic [14:0] dut_vec;

    int errors = 0;
    int checks = 0;

    // Model: 0 idle, 1 feed, 2 done; queue holds accepted-but-undelivered pixels.
    int         m_state = 0;
    int         m_acc   = 0;
    int         m_out   = 0;
    logic [7:0] m_q[$];

    always #5 clk = ~clk;

    lmfe_in_feeder #(
        .DEPTH(DEPTH), .AW(AW), .IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .host_data  (host_data),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .Din        (Din),
        .in_en      (in_en),
        .busy       (busy),
        .active     (active),
        .frame_done (frame_done),
        .fifo_level (fifo_level)
    );

    assign dut_vec = {host_ready, in_en, active, frame_done, fifo_level, Din};

    function automatic logic [14:0] exp_vec();
        logic       rdy, en, act, dn;
        logic [7:0] d;
        rdy = (m_state == 1) && (m_q.size() < DEPTH) && (m_acc < FP);
        en  = (m_state == 1) && (m_q.size() != 0) && !busy;
        act = (m_state != 0);
        dn  = (m_state == 2);
        d   = (m_q.size() != 0) ? m_q[0] : 8'h00;
        return {rdy, en, act, dn, 3'(m_q.size()), d};
    endfunction

    task automatic tick();
        logic [14:0] e;
        logic        push, pop;
        e    = exp_vec();
        pop  = e[13];
        push = host_valid && e[14];
        @(posedge clk);
        if (reset) begin
            m_state = 0; m_acc = 0; m_out = 0; m_q.delete();
        end else if (m_state == 0) begin
            if (start) begin m_state = 1; m_acc = 0; m_out = 0; end
        end else if (m_state == 1) begin
            if (pop)  begin void'(m_q.pop_front()); m_out++; end
            if (push) begin m_q.push_back(host_data); m_acc++; end
            if (pop && m_out == FP) m_state = 2;
        end else begin
            m_state = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; host_valid = 1'b1; busy = 1'b0; host_data = 8'h5A;
        tick();
        tick();
        reset = 1'b0; host_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_vec !== 15'h0) begin
            errors++; $display("FAIL reset_state got=%h exp=%h", dut_vec, 15'h0);
        end
        tick();
    endtask

    task automatic test_stream();
        int nx = 0, nd = 0;
        for (int c = 0; c < 30; c++) begin
            start = (c == 0); host_valid = 1'b1; busy = 1'b0;
            host_data = (m_acc < FP) ? 8'(8'h10 + m_acc) : 8'hFF;
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL stream c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            if (in_en) begin
                nx++; checks++;
                if (Din === 8'hFF) begin
                    errors++; $display("FAIL stream_excess c=%0d got=%h exp=not_ff", c, Din);
                end
            end
            if (frame_done) nd++;
            tick();
        end
        checks++; if (nx != FP) begin errors++; $display("FAIL stream_xfers got=%0d exp=%0d", nx, FP); end
        checks++; if (nd != 1)  begin errors++; $display("FAIL stream_done got=%0d exp=1", nd); end
    endtask

    task automatic test_busy_hold();
        int nx = 0;
        for (int c = 0; c < 40; c++) begin
            start = (c == 0); host_valid = 1'b1; busy = (c < 12);
            host_data = (m_acc < FP) ? 8'(8'h10 + m_acc) : 8'hFF;
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL busy_hold c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            if (c == 11) begin
                checks++;
                if (fifo_level !== 3'd4 || host_ready !== 1'b0 || in_en !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_sat got=lvl%0d rdy%b en%b exp=lvl4 rdy0 en0", fifo_level, host_ready, in_en);
                end
            end
            if (in_en) nx++;
            tick();
        end
        checks++; if (nx != FP) begin errors++; $display("FAIL busy_hold_xfers got=%0d exp=%0d", nx, FP); end
    endtask

    task automatic test_busy_toggle();
        int nx = 0;
        for (int c = 0; c < 40; c++) begin
            start = (c == 0); host_valid = 1'b1; busy = c[0];
            host_data = 8'($urandom_range(0, 254));
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL toggle c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            if (in_en) nx++;
            tick();
        end
        checks++; if (nx != FP) begin errors++; $display("FAIL toggle_xfers got=%0d exp=%0d", nx, FP); end
    endtask

    task automatic test_reset_mid();
        int nd = 0;
        for (int c = 0; c < 4; c++) begin
            start = (c == 0); host_valid = 1'b1; busy = 1'b1; host_data = 8'($urandom);
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL mid_fill c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            tick();
        end
        checks++;
        if (fifo_level !== 3'd3) begin errors++; $display("FAIL mid_level got=%0d exp=3", fifo_level); end
        reset = 1'b1; start = 1'b0; busy = 1'b0;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== 15'h0) begin
                errors++; $display("FAIL mid_after_reset c=%0d got=%h exp=%h", c, dut_vec, 15'h0);
            end
            if (frame_done) nd++;
            tick();
        end
        checks++; if (nd != 0) begin errors++; $display("FAIL mid_done got=%0d exp=0", nd); end
    endtask

    task automatic test_start_in_feed();
        int nx = 0, nd = 0;
        for (int c = 0; c < 40; c++) begin
            start = (c == 0) || (c == 3) || (c == 9); host_valid = 1'b1; busy = (c < 6);
            host_data = 8'($urandom_range(0, 254));
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL start_in_feed c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            if (in_en) nx++;
            if (frame_done) nd++;
            tick();
        end
        checks++; if (nx != FP) begin errors++; $display("FAIL sif_xfers got=%0d exp=%0d", nx, FP); end
        checks++; if (nd != 1)  begin errors++; $display("FAIL sif_done got=%0d exp=1", nd); end
    endtask

    task automatic test_random();
        int nd = 0;
        for (int c = 0; c < 300; c++) begin
            start      = ($urandom_range(0, 7) == 0);
            host_valid = ($urandom_range(0, 3) != 0);
            busy       = ($urandom_range(0, 2) == 0);
            host_data  = 8'($urandom);
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            if (frame_done) nd++;
            tick();
        end
        checks++; if (nd < 2) begin errors++; $display("FAIL random_frames got=%0d exp=>=2", nd); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_busy_hold();
        test_busy_toggle();
        test_reset_mid();
        test_stream();
        test_start_in_feed();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
